// File: rtl/filter_fir_sequencer.sv
// FIR filter control engine. It sits in front of a 512x32 storage RAM and keeps
// a circular sample history in the lower half and the Q15 coefficients in the upper half.
// For each accepted sample it runs NTAPS multiply-accumulate steps through the
// RAM read port, then emits a rounded and saturated 16-bit result.
module filter_fir_sequencer #(
   parameter int unsigned NTAPS = 32,
   parameter int unsigned ACCW  = 40
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   output logic        in_ready,
   input  logic        coef_we,
   input  logic [7:0]  coef_idx,
   input  logic [15:0] coef_data,
   output logic        coef_ready,
   output logic        wren,
   output logic [8:0]  wrptr,
   output logic [31:0] wrdata,
   output logic        rden,
   output logic [8:0]  rdptr,
   input  logic [31:0] rddata,
   output logic        out_valid,
   output logic [15:0] out_data,
   output logic        out_sat,
   input  logic        out_ready,
   output logic        busy
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] WRITE = 3'd1;
   localparam logic [2:0] RD_S  = 3'd2;
   localparam logic [2:0] RD_C  = 3'd3;
   localparam logic [2:0] DRAIN = 3'd4;
   localparam logic [2:0] OUT   = 3'd5;

   localparam logic [7:0] LAST_K = 8'(NTAPS - 1);

   logic [2:0]             state_q, state_d;
   logic [7:0]             wp_q, wp_d;
   logic [7:0]             k_q, k_d;
   logic signed [ACCW-1:0] acc_q, acc_d;
   logic [15:0]            s_q, s_d;
   logic [15:0]            samp_q, samp_d;
   logic                   out_valid_q, out_valid_d;
   logic [15:0]            out_data_q, out_data_d;
   logic                   out_sat_q, out_sat_d;
   logic [8:0]             wrptr_q, wrptr_d;
   logic [31:0]            wrdata_q, wrdata_d;
   logic [8:0]             rdptr_q, rdptr_d;

   // Upper half of the read word is never used; only the low 16 bits carry data.
   logic                   unused_rd;
   assign unused_rd = ^rddata[31:16];

   // Datapath: held sample times the coefficient arriving on the read port.
   logic signed [31:0]     prod;
   logic signed [ACCW-1:0] prod_ext;
   logic signed [ACCW-1:0] acc_sum;
   logic signed [ACCW-1:0] rnd;
   logic signed [ACCW-1:0] shifted;
   logic                   sat_hi;
   logic                   sat_lo;

   assign prod     = $signed(s_q) * $signed(rddata[15:0]);
   assign prod_ext = {{(ACCW-32){prod[31]}}, prod};
   assign acc_sum  = acc_q + prod_ext;
   assign rnd      = acc_sum + ACCW'(32'sd16384);
   assign shifted  = rnd >>> 15;
   // The value fits in 16 bits only if bits [ACCW-1:15] all match the sign bit.
   assign sat_hi   = ~shifted[ACCW-1] & (|shifted[ACCW-2:15]);
   assign sat_lo   = shifted[ACCW-1] & ~(&shifted[ACCW-2:15]);

   // Next-state and storage-port decode; wrptr/wrdata/rdptr hold unless overridden.
   always_comb begin
      state_d     = state_q;
      wp_d        = wp_q;
      k_d         = k_q;
      acc_d       = acc_q;
      s_d         = s_q;
      samp_d      = samp_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      wrptr_d     = wrptr_q;
      wrdata_d    = wrdata_q;
      rdptr_d     = rdptr_q;
      wren        = 1'b0;
      rden        = 1'b0;
      in_ready    = 1'b0;
      coef_ready  = 1'b0;

      case (state_q)
         IDLE: begin
            // rstb gating keeps the handshake and write strobes low while reset is held.
            coef_ready = rstb;
            in_ready   = rstb & ~coef_we;
            if (rstb && coef_we) begin
               wren     = 1'b1;
               wrptr_d  = {1'b1, coef_idx};
               wrdata_d = {{16{coef_data[15]}}, coef_data};
            end else if (in_valid && in_ready) begin
               samp_d  = in_data;
               acc_d   = '0;
               k_d     = 8'd0;
               state_d = WRITE;
            end
         end
         WRITE: begin
            wren     = 1'b1;
            wrptr_d  = {1'b0, wp_q};
            wrdata_d = {{16{samp_q[15]}}, samp_q};
            state_d  = RD_S;
         end
         RD_S: begin
            rden    = 1'b1;
            rdptr_d = {1'b0, wp_q - k_q};
            // rddata now holds the coefficient for tap k-1.
            if (k_q != 8'd0) begin
               acc_d = acc_sum;
            end
            state_d = RD_C;
         end
         RD_C: begin
            rden    = 1'b1;
            rdptr_d = {1'b1, k_q};
            s_d     = rddata[15:0];
            if (k_q == LAST_K) begin
               state_d = DRAIN;
            end else begin
               k_d     = k_q + 8'd1;
               state_d = RD_S;
            end
         end
         DRAIN: begin
            acc_d       = acc_sum;
            out_valid_d = 1'b1;
            out_sat_d   = sat_hi | sat_lo;
            out_data_d  = sat_hi ? 16'h7fff : (sat_lo ? 16'h8000 : shifted[15:0]);
            state_d     = OUT;
         end
         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               wp_d        = wp_q + 8'd1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; the asynchronous reset aborts any sample in flight.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q     <= IDLE;
         wp_q        <= '0;
         k_q         <= '0;
         acc_q       <= '0;
         s_q         <= '0;
         samp_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         wrptr_q     <= '0;
         wrdata_q    <= '0;
         rdptr_q     <= '0;
      end else begin
         state_q     <= state_d;
         wp_q        <= wp_d;
         k_q         <= k_d;
         acc_q       <= acc_d;
         s_q         <= s_d;
         samp_q      <= samp_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         wrptr_q     <= wrptr_d;
         wrdata_q    <= wrdata_d;
         rdptr_q     <= rdptr_d;
      end
   end

   assign wrptr     = wrptr_d;
   assign wrdata    = wrdata_d;
   assign rdptr     = rdptr_d;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_filter_fir_sequencer.sv
// Bench for filter_fir_sequencer. It models the storage RAM and keeps a reference
// FIR (sample history plus coefficient table) that predicts every output.
module tb_filter_fir_sequencer;

   localparam int NTAPS = 4;

   logic        clk;
   logic        rstb;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        coef_we;
   logic [7:0]  coef_idx;
   logic [15:0] coef_data;
   logic        coef_ready;
   logic        wren;
   logic [8:0]  wrptr;
   logic [31:0] wrdata;
   logic        rden;
   logic [8:0]  rdptr;
   logic [31:0] rddata;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_sat;
   logic        out_ready;
   logic        busy;

   filter_fir_sequencer #(.NTAPS(NTAPS), .ACCW(40)) dut (
      .clk       (clk),
      .rstb      (rstb),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .coef_we   (coef_we),
      .coef_idx  (coef_idx),
      .coef_data (coef_data),
      .coef_ready(coef_ready),
      .wren      (wren),
      .wrptr     (wrptr),
      .wrdata    (wrdata),
      .rden      (rden),
      .rdptr     (rdptr),
      .rddata    (rddata),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .out_ready (out_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Storage RAM: registered read, shares rstb and clears on reset.
   logic [31:0] mem [512];
   always @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         for (int i = 0; i < 512; i++) mem[i] <= '0;
         rddata <= '0;
      end else begin
         if (wren) mem[wrptr] <= wrdata;
         if (rden) rddata <= mem[rdptr];
      end
   end

   int n_pass;
   int n_total;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: plain circular history and coefficient table.
   int          hist  [256];
   int          coefm [256];
   int          mwp;
   logic [16:0] exp_q [$];

   task automatic model_reset();
      for (int i = 0; i < 256; i++) begin
         hist[i]  = 0;
         coefm[i] = 0;
      end
      mwp = 0;
      exp_q.delete();
   endtask

   task automatic model_sample(input logic [15:0] x);
      longint      acc;
      logic [15:0] d;
      logic        s;
      hist[mwp] = int'($signed(x));
      acc = 0;
      for (int k = 0; k < NTAPS; k++) begin
         acc += longint'(coefm[k]) * longint'(hist[(mwp - k) & 255]);
      end
      acc = (acc + 64'sd16384) >>> 15;
      if (acc > 32767) begin
         d = 16'h7fff;
         s = 1'b1;
      end else if (acc < -32768) begin
         d = 16'h8000;
         s = 1'b1;
      end else begin
         d = acc[15:0];
         s = 1'b0;
      end
      exp_q.push_back({s, d});
      mwp = (mwp + 1) % 256;
   endtask

   // Monitor: compares every presented output against the scoreboard head.
   always @(negedge clk) begin
      if (rstb) begin
         check("wren_rden_exclusive", {31'd0, wren & rden}, 32'd0);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
               check("out_data", {16'd0, out_data}, {16'd0, exp_q[0][15:0]});
               check("out_sat", {31'd0, out_sat}, {31'd0, exp_q[0][16]});
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic write_coef(input int idx, input logic [15:0] v);
      int n;
      coef_we   = 1'b1;
      coef_idx  = idx[7:0];
      coef_data = v;
      n = 0;
      @(negedge clk);
      while (!coef_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      check("coef_accept", {31'd0, coef_ready}, 32'd1);
      check("coef_wren", {31'd0, wren}, 32'd1);
      check("coef_wrptr", {23'd0, wrptr}, 32'(256 + idx));
      coefm[idx] = int'($signed(v));
      @(posedge clk);
      #1 coef_we = 1'b0;
   endtask

   // Offers a sample; on acceptance pushes the predicted output. Returns in cycle 1.
   task automatic send_sample(input logic [15:0] x, output int used_wp, output int waited);
      int n;
      in_valid = 1'b1;
      in_data  = x;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      waited  = n;
      used_wp = mwp;
      if (!in_ready) begin
         check("accept_timeout", {31'd0, in_ready}, 32'd1);
         in_valid = 1'b0;
      end else begin
         model_sample(x);
         @(posedge clk);
         #1 in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_outstanding", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          wpu;
      int          w;
      int          n;
      int          k;
      logic [8:0]  e;
      logic [15:0] x;
      logic [15:0] v;

      n_pass    = 0;
      n_total   = 0;
      rstb      = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      coef_we   = 1'b0;
      coef_idx  = '0;
      coef_data = '0;
      out_ready = 1'b1;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_wren", {31'd0, wren}, 32'd0);
      check("rst_rden", {31'd0, rden}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_coef_ready", {31'd0, coef_ready}, 32'd0);
      check("rst_wrptr", {23'd0, wrptr}, 32'd0);
      check("rst_rdptr", {23'd0, rdptr}, 32'd0);
      check("rst_wrdata", wrdata, 32'd0);
      check("rst_out_data", {16'd0, out_data}, 32'd0);
      check("rst_out_sat", {31'd0, out_sat}, 32'd0);
      rstb = 1'b1;
      @(negedge clk);
      check("idle_in_ready", {31'd0, in_ready}, 32'd1);
      check("idle_coef_ready", {31'd0, coef_ready}, 32'd1);
      check("idle_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;

      // Impulse response
      write_coef(0, 16'h4000);
      write_coef(1, 16'h2000);
      write_coef(2, 16'h1000);
      write_coef(3, 16'h0800);
      send_sample(16'h7fff, wpu, w);
      for (int i = 0; i < 5; i++) send_sample(16'h0000, wpu, w);
      drain();

      // Port timing for one sample
      x = 16'($urandom);
      send_sample(x, wpu, w);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         check("tm_in_ready", {31'd0, in_ready}, 32'd0);
         check("tm_out_valid", {31'd0, out_valid}, {31'd0, c == 11});
         if (c == 1) begin
            check("tm_wren", {31'd0, wren}, 32'd1);
            check("tm_wrptr", {23'd0, wrptr}, 32'(wpu));
            check("tm_wrdata", wrdata, {{16{x[15]}}, x});
         end else if (c <= 9) begin
            k = (c - 2) / 2;
            e = ((c % 2) == 0) ? 9'((wpu - k) & 255) : 9'(256 + k);
            check("tm_rden", {31'd0, rden}, 32'd1);
            check("tm_rdptr", {23'd0, rdptr}, {23'd0, e});
         end else begin
            check("tm_idle_strobes", {30'd0, wren, rden}, 32'd0);
         end
      end
      drain();

      // Saturation both directions
      for (int i = 0; i < 4; i++) write_coef(i, 16'h7fff);
      for (int i = 0; i < 4; i++) send_sample(16'h7fff, wpu, w);
      drain();
      for (int i = 0; i < 4; i++) send_sample(16'h8000, wpu, w);
      drain();

      // Backpressure, with coefficient writes attempted while busy
      out_ready = 1'b0;
      send_sample(16'h1234, wpu, w);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         coef_we   = 1'b1;
         coef_idx  = 8'd0;
         coef_data = 16'h1111;
         @(negedge clk);
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_coef_ready", {31'd0, coef_ready}, 32'd0);
         check("bp_no_wren", {31'd0, wren}, 32'd0);
         check("bp_wrptr", {23'd0, wrptr}, 32'(wpu));
      end
      @(posedge clk);
      #1;
      coef_we   = 1'b0;
      out_ready = 1'b1;
      drain();
      send_sample(16'h0400, wpu, w);
      drain();

      // Coefficient write wins over a simultaneous sample
      v = 16'h0100;
      x = 16'h2000;
      coef_we   = 1'b1;
      coef_idx  = 8'd1;
      coef_data = v;
      in_valid  = 1'b1;
      in_data   = x;
      @(negedge clk);
      check("prio_wren", {31'd0, wren}, 32'd1);
      check("prio_wrptr", {23'd0, wrptr}, 32'd257);
      check("prio_wrdata", wrdata, 32'h0000_0100);
      check("prio_in_ready", {31'd0, in_ready}, 32'd0);
      check("prio_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1 coef_we = 1'b0;
      coefm[1] = int'($signed(v));
      send_sample(x, wpu, w);
      check("prio_next_accept", 32'(w), 32'd0);
      drain();

      // Unit filter and pointer wrap
      write_coef(0, 16'h7fff);
      for (int i = 1; i < 4; i++) write_coef(i, 16'h0000);
      for (int i = 0; i < 300; i++) begin
         case (i % 50)
            7:       x = 16'h7fff;
            8:       x = 16'h8000;
            default: x = 16'($urandom);
         endcase
         send_sample(x, wpu, w);
         @(negedge clk);
         check("wrap_wrptr", {23'd0, wrptr}, 32'(wpu));
         repeat (3) @(negedge clk);
         check("wrap_rdptr_k1", {23'd0, rdptr}, 32'((wpu - 1) & 255));
      end
      drain();

      // Reset during RD_C of tap 2
      send_sample(16'h3000, wpu, w);
      repeat (6) @(posedge clk);
      #1;
      check("mid_rdptr_rdc2", {23'd0, rdptr}, 32'd258);
      #1 rstb = 1'b0;
      #1;
      check("mid_busy", {31'd0, busy}, 32'd0);
      check("mid_rden", {31'd0, rden}, 32'd0);
      check("mid_rdptr", {23'd0, rdptr}, 32'd0);
      check("mid_wrptr", {23'd0, wrptr}, 32'd0);
      check("mid_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_in_ready", {31'd0, in_ready}, 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rstb = 1'b1;
      @(posedge clk);
      #1;
      write_coef(0, 16'(16'h2000 + 16'($urandom_range(0, 4095))));
      for (int i = 1; i < 4; i++) write_coef(i, 16'($urandom));
      x = 16'($urandom);
      send_sample(x, wpu, w);
      @(negedge clk);
      check("post_rst_wrptr", {23'd0, wrptr}, 32'd0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
